// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the reduced RISC-V core.
// Drives a shared-memory, shared-ALU datapath through FETCH/DECODE/execute states.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUOp,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRAN  = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_e     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr;

  // Enables before the reset gate
  logic mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
  logic instr_done_c, illegal_c;

  assign opcode       = Instr[6:0];
  assign funct3       = Instr[14:12];
  assign unused_instr = ^{Instr[31:15], Instr[11:7]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRAN:           state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; Mealy terms only where the handshake or Zero must act this cycle
  always_comb begin
    mem_req_c    = 1'b0;
    AdrSrc       = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
          OP_BRAN, OP_JAL, OP_JALR: illegal_c = 1'b0;
          default:                  illegal_c = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c    = 1'b1;
        mem_write_c  = 1'b1;
        AdrSrc       = 1'b1;
        instr_done_c = mem_ready;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        instr_done_c = 1'b1;
        case (funct3)
          3'b000:  pc_write_c = Zero;
          3'b001:  pc_write_c = ~Zero;
          default: pc_write_c = 1'b0;
        endcase
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_JAL: begin
        pc_write_c = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
      end
      default: ;
    endcase
  end

  // Immediate format straight from the opcode
  always_comb begin
    case (opcode)
      OP_STORE: ImmSrc = 2'b01;
      OP_BRAN:  ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  // Reset suppresses every write/request so an aborted instruction leaves no trace
  assign mem_req    = mem_req_c    & ~rst;
  assign MemWrite   = mem_write_c  & ~rst;
  assign IRWrite    = ir_write_c   & ~rst;
  assign PCWrite    = pc_write_c   & ~rst;
  assign RegWrite   = reg_write_c  & ~rst;
  assign instr_done = instr_done_c & ~rst;
  assign illegal    = illegal_c    & ~rst;
  assign state      = state_q;

endmodule
